// File: rtl/fp_sum_normalizer_if.sv
// Handshake and data bundle between the aligned-sum producer and fp_sum_normalizer.
// master drives the raw sum and consumes the packed result; slave is the normalizer.
interface fp_sum_normalizer_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    logic                    vld_i;
    logic                    rdy_o;
    logic                    special_i;
    logic                    sign_i;
    logic [EXP_W-1:0]        exp_i;
    logic [MANT_W+3:0]       mant_i;
    logic                    vld_o;
    logic [EXP_W+MANT_W:0]   res_o;
    logic                    status_o;

    modport master (
        output vld_i, special_i, sign_i, exp_i, mant_i,
        input  rdy_o, vld_o, res_o, status_o
    );

    modport slave (
        input  vld_i, special_i, sign_i, exp_i, mant_i,
        output rdy_o, vld_o, res_o, status_o
    );
endinterface

// File: rtl/fp_sum_normalizer.sv
// Post-add normalizer: shifts the raw aligned sum one bit per clock, rounds to
// nearest-even and packs {sign, exp, frac} with a NaN/Inf status flag.
//
// state | meaning
// IDLE  | ready; capture raw sum on vld_i
// NORM  | one carry right-shift or cancellation left-shift per edge
// ROUND | round, pack, register result and pulse vld_o
module fp_sum_normalizer #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fp_sum_normalizer_if.slave  bus
);
    localparam int MW = MANT_W + 4;
    localparam int RW = 1 + EXP_W + MANT_W;
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND} state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic              special_q, special_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic [MW-1:0]     mant_q, mant_d;
    logic              vld_q, vld_d;
    logic [RW-1:0]     res_q, res_d;
    logic              status_q, status_d;

    logic              rnd_inc;
    logic [MANT_W+1:0] rnd_sum;
    logic              rnd_hid;
    logic [MANT_W-1:0] rnd_frac;
    logic [EXP_W:0]    rnd_exp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            special_q <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            vld_q     <= 1'b0;
            res_q     <= '0;
            status_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            special_q <= special_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            vld_q     <= vld_d;
            res_q     <= res_d;
            status_q  <= status_d;
        end
    end

    // Round-to-nearest-even on {hidden, fraction}; a carry-out renormalizes to 1.0.
    always_comb begin
        rnd_inc  = mant_q[1] & (mant_q[0] | mant_q[2]);
        rnd_sum  = {1'b0, mant_q[MANT_W+2:2]} + {{(MANT_W+1){1'b0}}, rnd_inc};
        rnd_hid  = rnd_sum[MANT_W];
        rnd_frac = rnd_sum[MANT_W-1:0];
        rnd_exp  = exp_q;
        if (rnd_sum[MANT_W+1]) begin
            rnd_hid  = 1'b1;
            rnd_frac = '0;
            rnd_exp  = exp_q + EXP_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        special_d = special_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        vld_d     = 1'b0;
        res_d     = res_q;
        status_d  = status_q;

        case (state_q)
            S_IDLE: begin
                if (bus.vld_i) begin
                    sign_d    = bus.sign_i;
                    special_d = bus.special_i;
                    exp_d     = {1'b0, bus.exp_i};
                    mant_d    = bus.mant_i;
                    state_d   = bus.special_i ? S_ROUND : S_NORM;
                end
            end
            S_NORM: begin
                if (mant_q[MW-1]) begin
                    mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + EXP_ONE;
                end else if (!mant_q[MW-2] && (|mant_q[MW-1:1]) && (exp_q > EXP_ONE)) begin
                    mant_d = {mant_q[MW-2:1], 1'b0, mant_q[0]};
                    exp_d  = exp_q - EXP_ONE;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                vld_d   = 1'b1;
                state_d = S_IDLE;
                if (special_q) begin
                    res_d    = {sign_q, {EXP_W{1'b1}}, mant_q[MANT_W+1:2]};
                    status_d = 1'b1;
                end else if (!rnd_hid && (rnd_frac == '0)) begin
                    res_d    = '0;
                    status_d = 1'b0;
                end else if (rnd_hid && (rnd_exp >= EXP_MAX)) begin
                    res_d    = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                    status_d = 1'b1;
                end else begin
                    res_d    = {sign_q, (rnd_hid ? rnd_exp[EXP_W-1:0] : {EXP_W{1'b0}}), rnd_frac};
                    status_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rdy_o    = (state_q == S_IDLE);
    assign bus.vld_o    = vld_q;
    assign bus.res_o    = res_q;
    assign bus.status_o = status_q;
endmodule
